// File: rtl/taillight_pkg.sv
// Shared types and default timing constants for the tail-light front end.
package taillight_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT,
    HAZARD
  } ts_state_t;

  localparam int unsigned DEB_CYCLES_DEF    = 4;
  localparam int unsigned TICK_DIV_DEF      = 8;
  localparam int unsigned TIMEOUT_TICKS_DEF = 24;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw cabin input.
module input_debounce
  import taillight_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int unsigned   CW   = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples; any agreement restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        cnt  <= '0;
        db   <= s2;
        rise <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn-signal front end: conditions levers/hazard button, arbitrates into one-hot lt/rt/haz,
// produces the blink-step tick and auto-cancels a held turn after a tick timeout.
module turn_signal_ctrl
  import taillight_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic lever_l,
  input  logic lever_r,
  input  logic haz_btn,
  output logic lt,
  output logic rt,
  output logic haz,
  output logic tick,
  output logic cancelled
);

  localparam int unsigned   PW   = $clog2(TICK_DIV + 1);
  localparam int unsigned   TW   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS - 1);

  logic          db_l, db_r, db_h;
  logic          rise_l, rise_r, rise_h;
  logic          unused_rise;
  logic          hz_latch, hz_eff;
  logic          canc_eff, canc_n, timeout_now;
  ts_state_t     state, state_n, dir, cdir, cdir_n;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;

  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .clk(clk), .rst(rst), .raw(lever_l), .db(db_l), .rise(rise_l)
  );
  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .clk(clk), .rst(rst), .raw(lever_r), .db(db_r), .rise(rise_r)
  );
  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_h (
    .clk(clk), .rst(rst), .raw(haz_btn), .db(db_h), .rise(rise_h)
  );

  // Lever edges are not needed; only their levels drive the arbitration.
  assign unused_rise = rise_l ^ rise_r ^ db_h;

  // The toggle is folded in combinationally so a press reaches haz with the same latency as a lever.
  assign hz_eff = hz_latch ^ rise_h;
  assign tick   = (state != IDLE) && (pcnt == PMAX);

  // Next-state arbitration: hazard first, then a non-cancelled direction, else idle.
  always_comb begin
    dir = IDLE;
    if (db_l && !db_r)      dir = LEFT;
    else if (db_r && !db_l) dir = RIGHT;

    canc_eff    = cancelled && (dir == cdir);
    timeout_now = !hz_eff && tick && (tcnt == TMAX) && (dir == state);

    state_n = IDLE;
    canc_n  = canc_eff;
    cdir_n  = cdir;
    if (hz_eff) begin
      state_n = HAZARD;
    end else if (timeout_now) begin
      canc_n = 1'b1;
      cdir_n = dir;
    end else if (dir != IDLE && !canc_eff) begin
      state_n = dir;
    end
  end

  // State, hazard latch, cancel flag and registered one-hot outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hz_latch  <= 1'b0;
      cancelled <= 1'b0;
      cdir      <= IDLE;
      lt        <= 1'b0;
      rt        <= 1'b0;
      haz       <= 1'b0;
    end else begin
      state     <= state_n;
      hz_latch  <= hz_eff;
      cancelled <= canc_n;
      cdir      <= cdir_n;
      lt        <= (state_n == LEFT);
      rt        <= (state_n == RIGHT);
      haz       <= (state_n == HAZARD);
    end
  end

  // Blink prescaler and tick-based timeout; both restart on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      tcnt <= '0;
    end else if (state_n != state || state_n == IDLE) begin
      pcnt <= '0;
      tcnt <= '0;
    end else begin
      pcnt <= (pcnt == PMAX) ? '0 : pcnt + 1'b1;
      if (tick && state != HAZARD && tcnt != TMAX) tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Self-checking bench for turn_signal_ctrl with a behavioural reference model.
module tb_turn_signal_ctrl;

  localparam int DEB = 4;
  localparam int TD  = 8;
  localparam int TO  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lever_l = 1'b0, lever_r = 1'b0, haz_btn = 1'b0;
  logic lt, rt, haz, tick, cancelled;

  int checks = 0;
  int passes = 0;

  turn_signal_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TD), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst(rst), .lever_l(lever_l), .lever_r(lever_r), .haz_btn(haz_btn),
    .lt(lt), .rt(rt), .haz(haz), .tick(tick), .cancelled(cancelled)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 left, 2 right, 3 hazard; m_age = cycles spent in current state.
  int m_st, m_age, m_cdir, m_dir, m_nst;
  int sh_l, sh_r, sh_h, win;
  bit m_hz, m_canc, m_dl, m_dr, m_dh, m_rise, m_hzn, m_tick, m_tmo, m_ceff, m_old;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_age = 0; m_cdir = 0; m_hz = 0; m_canc = 0;
      m_dl = 0; m_dr = 0; m_dh = 0; m_rise = 0;
      sh_l = 0; sh_r = 0; sh_h = 0;
    end else begin
      m_hzn  = m_hz ^ m_rise;
      m_dir  = (m_dl && !m_dr) ? 1 : ((m_dr && !m_dl) ? 2 : 0);
      m_tick = (m_st != 0) && ((m_age % TD) == TD - 1);
      m_tmo  = !m_hzn && m_tick && (m_dir == m_st) && (((m_age + 1) / TD) >= TO);
      m_ceff = m_canc && (m_dir == m_cdir);
      m_canc = m_ceff;
      if (m_hzn) m_nst = 3;
      else if (m_tmo) begin m_nst = 0; m_canc = 1; m_cdir = m_dir; end
      else m_nst = m_ceff ? 0 : m_dir;
      m_age = (m_nst != m_st || m_nst == 0) ? 0 : m_age + 1;
      m_st  = m_nst;
      m_hz  = m_hzn;
      // Debounced level = the synchronised value once the last DEB synchronised samples agree.
      sh_l = (sh_l << 1) | int'(lever_l);
      sh_r = (sh_r << 1) | int'(lever_r);
      sh_h = (sh_h << 1) | int'(haz_btn);
      win = (sh_l >> 2) & ((1 << DEB) - 1);
      if (win == (1 << DEB) - 1) m_dl = 1; else if (win == 0) m_dl = 0;
      win = (sh_r >> 2) & ((1 << DEB) - 1);
      if (win == (1 << DEB) - 1) m_dr = 1; else if (win == 0) m_dr = 0;
      m_old = m_dh;
      win = (sh_h >> 2) & ((1 << DEB) - 1);
      if (win == (1 << DEB) - 1) m_dh = 1; else if (win == 0) m_dh = 0;
      m_rise = m_dh && !m_old;
    end
  end

  function automatic logic [4:0] mexp();
    return {m_st == 1, m_st == 2, m_st == 3, (m_st != 0) && ((m_age % TD) == TD - 1), m_canc};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({lt, rt, haz, tick} !== 4'b0) $display("FAIL reset_hold cyc=%0d got=%b exp=0000", i, {lt, rt, haz, tick});
      else passes++;
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (lt !== (i >= 7)) $display("FAIL reset_release_lt edge=%0d got=%b exp=%b", i, lt, (i >= 7));
      else passes++;
    end
  endtask

  task automatic test_glitch();
    lever_l = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if ({lt, rt, haz, tick, cancelled} !== mexp()) $display("FAIL settle_model cyc=%0d got=%b exp=%b", i, {lt, rt, haz, tick, cancelled}, mexp());
      else passes++;
    end
    lever_l = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 2) lever_l = 1'b0;
      checks++;
      if (lt !== 1'b0 || {lt, rt, haz, tick, cancelled} !== mexp()) $display("FAIL glitch_lt cyc=%0d got=%b exp=%b", i, {lt, rt, haz, tick, cancelled}, mexp());
      else passes++;
    end
  endtask

  task automatic test_hold_tick();
    int ntick = 0, last = 0;
    lever_l = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      checks++;
      if ({lt, rt, haz, tick, cancelled} !== mexp()) $display("FAIL hold_model cyc=%0d got=%b exp=%b", i, {lt, rt, haz, tick, cancelled}, mexp());
      else passes++;
      if (tick === 1'b1) begin
        if (ntick > 0) begin
          checks++;
          if (i - last !== TD) $display("FAIL tick_period got=%0d exp=%0d", i - last, TD);
          else passes++;
        end
        ntick++;
        last = i;
      end
    end
    checks++;
    if (lt !== 1'b1 || ntick !== 3) $display("FAIL hold_lt_ticks got lt=%b ticks=%0d exp lt=1 ticks=3", lt, ntick);
    else passes++;
    lever_l = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
  endtask

  task automatic test_timeout();
    int nlt = 0, clr = -1;
    lever_l = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (lt === 1'b1) nlt++;
      checks++;
      if ({lt, rt, haz, tick, cancelled} !== mexp()) $display("FAIL timeout_model cyc=%0d got=%b exp=%b", i, {lt, rt, haz, tick, cancelled}, mexp());
      else passes++;
    end
    checks++;
    if (nlt !== TD * TO || lt !== 1'b0 || cancelled !== 1'b1)
      $display("FAIL timeout_cancel got lt_cycles=%0d lt=%b canc=%b exp 32/0/1", nlt, lt, cancelled);
    else passes++;
    lever_l = 1'b0;
    for (int i = 1; i <= 20 && clr < 0; i++) begin
      @(negedge clk);
      if (cancelled === 1'b0) clr = i;
    end
    checks++;
    if (clr !== DEB + 3) $display("FAIL cancel_clear got_cycle=%0d exp=%0d", clr, DEB + 3);
    else passes++;
  endtask

  task automatic test_hazard();
    int nlt = 0;
    lever_l = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    haz_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) haz_btn = 1'b0;
      checks++;
      if ({lt, rt, haz, tick, cancelled} !== mexp()) $display("FAIL haz_on_model cyc=%0d got=%b exp=%b", i, {lt, rt, haz, tick, cancelled}, mexp());
      else passes++;
    end
    checks++;
    if (haz !== 1'b1 || lt !== 1'b0) $display("FAIL haz_on got haz=%b lt=%b exp haz=1 lt=0", haz, lt);
    else passes++;
    haz_btn = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 6) haz_btn = 1'b0;
      if (lt === 1'b1) nlt++;
      checks++;
      if (i == 7 && {lt, haz} !== 2'b10) $display("FAIL haz_off_lt got lt=%b haz=%b exp lt=1 haz=0", lt, haz);
      else if ({lt, rt, haz, tick, cancelled} !== mexp()) $display("FAIL haz_off_model cyc=%0d got=%b exp=%b", i, {lt, rt, haz, tick, cancelled}, mexp());
      else passes++;
    end
    checks++;
    if (nlt !== TD * TO) $display("FAIL haz_timeout_restart got=%0d exp=%0d", nlt, TD * TO);
    else passes++;
    lever_l = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
  endtask

  task automatic test_both();
    int gaps = 0;
    lever_l = 1'b1;
    lever_r = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if ({lt, rt, haz} !== 3'b000) $display("FAIL both_idle cyc=%0d got=%b exp=000", i, {lt, rt, haz});
      else passes++;
    end
    lever_l = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (rt !== (i >= 7)) $display("FAIL drop_l_rt cyc=%0d got=%b exp=%b", i, rt, (i >= 7));
      else passes++;
    end
    lever_l = 1'b1;
    lever_r = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if ((lt | rt) !== 1'b1) gaps++;
      checks++;
      if ({lt, rt, haz, tick, cancelled} !== mexp()) $display("FAIL swap_model cyc=%0d got=%b exp=%b", i, {lt, rt, haz, tick, cancelled}, mexp());
      else passes++;
    end
    checks++;
    if (gaps !== 0 || lt !== 1'b1) $display("FAIL direct_swap got idle_cycles=%0d lt=%b exp 0/1", gaps, lt);
    else passes++;
    lever_l = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
  endtask

  task automatic test_async_reset();
    haz_btn = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 6) haz_btn = 1'b0;
    end
    checks++;
    if (haz !== 1'b1) $display("FAIL pre_reset_haz got=%b exp=1", haz);
    else passes++;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({lt, rt, haz, tick, cancelled} !== 5'b0) $display("FAIL async_reset got=%b exp=00000", {lt, rt, haz, tick, cancelled});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      checks++;
      if (haz !== 1'b0 || {lt, rt, haz, tick, cancelled} !== mexp()) $display("FAIL post_reset cyc=%0d got=%b exp=%b", i, {lt, rt, haz, tick, cancelled}, mexp());
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if ({lt, rt, haz, tick, cancelled} !== mexp()) $display("FAIL random_model cyc=%0d got=%b exp=%b", i, {lt, rt, haz, tick, cancelled}, mexp());
      else passes++;
      checks++;
      if ((32'(lt) + 32'(rt) + 32'(haz)) > 1) $display("FAIL onehot cyc=%0d got=%b exp=at most one", i, {lt, rt, haz});
      else passes++;
      if ($urandom_range(0, 15) == 0) lever_l = ~lever_l;
      if ($urandom_range(0, 15) == 0) lever_r = ~lever_r;
      if ($urandom_range(0, 11) == 0) haz_btn = ~haz_btn;
    end
  endtask

  initial begin
    lever_l = 1'b1;
    test_reset();
    test_glitch();
    test_hold_tick();
    test_timeout();
    test_hazard();
    test_both();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
